// File: rtl/ram_bank_if.sv
// Bus bundle for ram_bank: write port, read port and clear-engine control/status.
interface ram_bank_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              load_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [WIDTH-1:0]  din_i;
  logic [ADDR_W-1:0] raddr_i;
  logic              clr_i;
  logic [WIDTH-1:0]  dout_o;
  logic              busy_o;

  modport master (
    output load_i, waddr_i, din_i, raddr_i, clr_i,
    input  dout_o, busy_o
  );

  modport slave (
    input  load_i, waddr_i, din_i, raddr_i, clr_i,
    output dout_o, busy_o
  );
endinterface

// File: rtl/ram_bank.sv
// WIDTH x 2**ADDR_W RAM bank with one write port, a registered read port and a clear sweep engine.
// Define RAM_BYPASS_EN for write-first same-address read-during-write; default build is read-first.
module ram_bank #(
  parameter int              WIDTH   = 16,
  parameter int              ADDR_W  = 3,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ram_bank_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [WIDTH-1:0]  dout_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  rd_d;

  // The sweep owns the write port; in IDLE a clear request suppresses the user write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    wr_data = CLR_VAL;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
    end else if (!bus.clr_i && bus.load_i) begin
      wr_en   = 1'b1;
      wr_addr = bus.waddr_i;
      wr_data = bus.din_i;
    end
  end

  always_comb begin
`ifdef RAM_BYPASS_EN
    if (bus.load_i && (bus.waddr_i == bus.raddr_i)) begin
      rd_d = bus.din_i;
    end else begin
      rd_d = mem_q[bus.raddr_i];
    end
`else
    rd_d = mem_q[bus.raddr_i];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          dout_q <= '0;
          // ptr wraps to 0 on its own after the last word
          ptr_q  <= ptr_q + ADDR_W'(1);
          if (ptr_q == {ADDR_W{1'b1}}) begin
            state_q <= IDLE;
          end
        end
        default: begin
          if (bus.clr_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            dout_q  <= '0;
          end else begin
            dout_q <= rd_d;
          end
        end
      endcase
    end
  end

  assign bus.dout_o = dout_q;
  assign bus.busy_o = (state_q == CLEAR);
endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank (WIDTH=16, ADDR_W=3): reset sweep, read/write, clear priority, async reset.
module tb_ram_bank;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ram_bank_if #(.WIDTH(16), .ADDR_W(3)) bus ();

  ram_bank #(.WIDTH(16), .ADDR_W(3), .CLR_VAL(16'h0000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_i  = 1'b0;
    bus.clr_i   = 1'b0;
    bus.waddr_i = '0;
    bus.raddr_i = '0;
    bus.din_i   = '0;
  endtask

  // Counts edges until busy_o drops, bounded at 20.
  task automatic count_sweep(input string name, input int start);
    int cnt;
    cnt = start;
    while (bus.busy_o === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== 8) begin
      errors++;
      $display("FAIL %s: busy edges=%0d expected=8", name, cnt);
    end
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    bus.load_i  = 1'b0;
    bus.raddr_i = a;
    tick();
    checks++;
    if (bus.dout_o !== exp) begin
      errors++;
      $display("FAIL %s: addr=%0d dout=%h expected=%h", name, a, bus.dout_o, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: busy=%b expected=1", bus.busy_o);
    end
    checks++;
    if (bus.dout_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_dout: dout=%h expected=0000", bus.dout_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    count_sweep("reset_sweep", 0);
    for (int a = 0; a < 8; a++) begin
      read_check("reset_read", 3'(a), 16'h0000);
    end
  endtask

  task automatic test_write_read();
    bus.load_i  = 1'b1;
    bus.waddr_i = 3'd3;
    bus.din_i   = 16'hBEEF;
    tick();
    bus.waddr_i = 3'd7;
    bus.din_i   = 16'h1234;
    tick();
    bus.load_i = 1'b0;
    read_check("wr_read3", 3'd3, 16'hBEEF);
    bus.raddr_i = 3'd7;
    #1;
    checks++;
    if (bus.dout_o !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_latency: dout=%h expected=beef", bus.dout_o);
    end
    read_check("wr_read7", 3'd7, 16'h1234);
  endtask

  task automatic test_rdw();
    logic [15:0] exp;
    bus.load_i  = 1'b1;
    bus.waddr_i = 3'd5;
    bus.din_i   = 16'h0001;
    tick();
    bus.raddr_i = 3'd5;
    bus.din_i   = 16'hA5A5;
    tick();
`ifdef RAM_BYPASS_EN
    exp = 16'hA5A5;
`else
    exp = 16'h0001;
`endif
    checks++;
    if (bus.dout_o !== exp) begin
      errors++;
      $display("FAIL rdw_same_addr: dout=%h expected=%h", bus.dout_o, exp);
    end
    read_check("rdw_next_read", 3'd5, 16'hA5A5);
  endtask

  task automatic test_clear_wins();
    bus.clr_i   = 1'b1;
    bus.load_i  = 1'b1;
    bus.waddr_i = 3'd2;
    bus.din_i   = 16'hFFFF;
    tick();
    bus.clr_i  = 1'b0;
    bus.load_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.dout_o !== 16'h0000) begin
      errors++;
      $display("FAIL clr_enter: busy=%b dout=%h expected busy=1 dout=0000", bus.busy_o, bus.dout_o);
    end
    count_sweep("clr_sweep", 0);
    read_check("clr_mem2", 3'd2, 16'h0000);
    read_check("clr_mem3", 3'd3, 16'h0000);
  endtask

  task automatic test_sweep_ignores();
    int cnt;
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i   = 1'b0;
    bus.raddr_i = 'x;
    bus.din_i   = 'x;
    cnt = 0;
    while (bus.busy_o === 1'b1 && cnt < 20) begin
      bus.clr_i  = (cnt == 3);
      bus.load_i = (cnt == 4);
      if (cnt == 4) begin
        bus.waddr_i = 3'd1;
        bus.din_i   = 16'h7777;
      end else begin
        bus.din_i = 'x;
      end
      tick();
      cnt++;
      if (cnt == 6) begin
        checks++;
        if (bus.dout_o !== 16'h0000) begin
          errors++;
          $display("FAIL sweep_dout: dout=%h expected=0000", bus.dout_o);
        end
      end
    end
    bus.clr_i  = 1'b0;
    bus.load_i = 1'b0;
    bus.din_i  = '0;
    checks++;
    if (cnt !== 8) begin
      errors++;
      $display("FAIL sweep_no_restart: busy edges=%0d expected=8", cnt);
    end
    read_check("sweep_mem1", 3'd1, 16'h0000);
  endtask

  task automatic test_async_reset();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.dout_o !== 16'h0000) begin
      errors++;
      $display("FAIL arst_sweep: busy=%b dout=%h expected busy=1 dout=0000", bus.busy_o, bus.dout_o);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    count_sweep("arst_sweep_len", 0);

    bus.load_i  = 1'b1;
    bus.waddr_i = 3'd6;
    bus.din_i   = 16'h4321;
    tick();
    read_check("arst_pre_read", 3'd6, 16'h4321);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dout_o !== 16'h0000 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_idle: busy=%b dout=%h expected busy=1 dout=0000", bus.busy_o, bus.dout_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    count_sweep("arst_idle_sweep", 0);
    read_check("arst_mem6", 3'd6, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_rdw();
    test_clear_wins();
    test_sweep_ignores();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
